// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer for the fetch stage: decodes calls, returns and coroutine swaps,
// drives the external stack and rewinds wrong-path pushes after a mispredict flush.
module ras_ctrl #(
  parameter int RAS_INDEX = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_instr,
  input  logic [31:0] i_fetch_pc,
  output logic        o_fetch_ready,
  output logic        o_pred_valid,
  output logic [31:0] o_pred_target,
  input  logic        i_commit_call,
  input  logic        i_commit_ret,
  input  logic        i_flush,
  output logic        o_ras_push,
  output logic        o_ras_pop,
  output logic [31:0] o_ras_addr_in,
  input  logic [31:0] i_ras_addr_out,
  input  logic        i_ras_empty
);

  localparam logic [RAS_INDEX:0] MAX_DEPTH = {1'b1, {RAS_INDEX{1'b0}}};
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {IDLE, SWAP, REPAIR} state_t;

  state_t             r_state;
  logic [RAS_INDEX:0] r_specDepth;
  logic [RAS_INDEX:0] r_commitDepth;
  logic [31:0]        r_swapAddr;

  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic               w_rdLink;
  logic               w_rs1Link;
  logic               w_isJal;
  logic               w_isJalr;
  logic               w_isCall;
  logic               w_isRet;
  logic               w_isCor;
  logic               w_unused;
  logic               w_idle;
  logic               w_accept;
  logic               w_doCall;
  logic               w_doRetLike;
  logic               w_predValid;
  logic               w_swapPush;
  logic               w_repairPop;
  logic [31:0]        w_linkAddr;
  logic [RAS_INDEX:0] w_specInc;
  logic [RAS_INDEX:0] w_commitNext;

  assign w_rd      = i_fetch_instr[11:7];
  assign w_rs1     = i_fetch_instr[19:15];
  assign w_rdLink  = (w_rd == 5'd1) || (w_rd == 5'd5);
  assign w_rs1Link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_isJal   = (i_fetch_instr[6:0] == OPC_JAL);
  assign w_isJalr  = (i_fetch_instr[6:0] == OPC_JALR);
  assign w_unused  = ^{i_fetch_instr[31:20], i_fetch_instr[14:12]};

  // A JALR linking through the same register it jumps through is a plain call, not a swap
  assign w_isCall = (w_isJal & w_rdLink) |
                    (w_isJalr & w_rdLink & (~w_rs1Link | (w_rd == w_rs1)));
  assign w_isRet  = w_isJalr & ~w_rdLink & w_rs1Link;
  assign w_isCor  = w_isJalr & w_rdLink & w_rs1Link & (w_rd != w_rs1);

  assign w_idle      = (r_state == IDLE) & ~i_rst;
  assign w_accept    = i_fetch_valid & o_fetch_ready;
  assign w_doCall    = w_accept & w_isCall;
  assign w_doRetLike = w_accept & (w_isRet | w_isCor);
  assign w_predValid = w_doRetLike & ~i_ras_empty;
  assign w_swapPush  = (r_state == SWAP) & ~i_rst & ~i_flush;
  assign w_linkAddr  = i_fetch_pc + 32'd4;
  assign w_specInc   = (r_specDepth == MAX_DEPTH) ? r_specDepth : r_specDepth + 1'b1;

  // Committed depth as it will be after this cycle's retire pulses; REPAIR rewinds towards it
  always_comb begin
    w_commitNext = r_commitDepth;
    if (i_commit_call && !i_commit_ret && r_commitDepth != MAX_DEPTH)
      w_commitNext = r_commitDepth + 1'b1;
    else if (i_commit_ret && !i_commit_call && r_commitDepth != '0)
      w_commitNext = r_commitDepth - 1'b1;
  end

  assign w_repairPop = (r_state == REPAIR) & ~i_rst & ~i_flush & (r_specDepth > w_commitNext);

  assign o_fetch_ready = w_idle & ~i_flush;
  assign o_pred_valid  = w_predValid;
  assign o_pred_target = w_predValid ? i_ras_addr_out : 32'd0;
  assign o_ras_push    = w_doCall | w_swapPush;
  assign o_ras_pop     = w_predValid | w_repairPop;
  assign o_ras_addr_in = w_doCall ? w_linkAddr : (w_swapPush ? r_swapAddr : 32'd0);

  // Depth tracking mirrors the stack pointer exactly; a flush overrides whatever state we are in
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_specDepth   <= '0;
      r_commitDepth <= '0;
      r_swapAddr    <= '0;
    end else begin
      r_commitDepth <= w_commitNext;
      if (i_flush) begin
        r_state <= REPAIR;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_doCall)
              r_specDepth <= w_specInc;
            else if (w_predValid)
              r_specDepth <= r_specDepth - 1'b1;
            if (w_accept && w_isCor) begin
              r_swapAddr <= w_linkAddr;
              r_state    <= SWAP;
            end
          end
          SWAP: begin
            r_specDepth <= w_specInc;
            r_state     <= IDLE;
          end
          REPAIR: begin
            if (w_repairPop) begin
              r_specDepth <= r_specDepth - 1'b1;
            end else begin
              // Entries overwritten by wrong-path pushes cannot be recovered, so trust the stack
              r_commitDepth <= r_specDepth;
              r_state       <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
